fog_lut_evaluator: RTL
======================

Name: fog_lut_evaluator

Overview:
- Sits directly downstream of the command parser's fog LUT stream and loads the 33-word fog function table it emits.
- Evaluates the fog intensity for each fragment depth using piecewise-linear interpolation over 32 segments.
- Feeds the fragment pipeline, which blends toward the configured fog color using the 8-bit intensity produced here.

Parameters:
- CMD_STREAM_WIDTH, 32, width of the LUT load stream; only 32 is supported.
- USER_WIDTH, 16, width of the fragment sideband tag carried alongside each depth sample unchanged.

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous active-high reset
- s_fog_lut_axis_tvalid  in  1  LUT load beat valid
- s_fog_lut_axis_tready  out  1  LUT load ready
- s_fog_lut_axis_tlast  in  1  last LUT beat
- s_fog_lut_axis_tdata  in  CMD_STREAM_WIDTH  LUT word
- s_depth_axis_tvalid  in  1  depth sample valid
- s_depth_axis_tready  out  1  depth sample ready
- s_depth_axis_tdata  in  16  unsigned fragment depth z
- s_depth_axis_tuser  in  USER_WIDTH  fragment tag
- m_fog_axis_tvalid  out  1  intensity valid
- m_fog_axis_tready  in  1  downstream ready
- m_fog_axis_tdata  out  8  fog intensity, 0..255
- m_fog_axis_tuser  out  USER_WIDTH  tag, passed through
- lutValid  out  1  a complete table is loaded

Behaviour:
- Reset values: s_fog_lut_axis_tready=0, s_depth_axis_tready=0, m_fog_axis_tvalid=0, lutValid=0, load counter=0, FSM=IDLE. Table RAM contents are not reset.
- Clock and reset: one clock; reset is synchronous and active-high.
- LUT word 0: [15:0] lower bound Z0, [20:16] shift S (0..31); other bits are ignored.
- LUT words 1..32: entry i-1, with [31:16] unsigned offset (Q8.8) and [15:0] signed slope (Q8.8).
- Load FSM states: IDLE, LOAD, DRAIN.
- IDLE -> LOAD when s_fog_lut_axis_tvalid=1 and the evaluation pipeline is empty.
  - In IDLE, while s_fog_lut_axis_tvalid=1, s_depth_axis_tready is forced to 0 so the pipeline drains.
- LOAD: s_fog_lut_axis_tready=1. Each accepted beat writes word[counter] and increments counter.
  - lutValid drops to 0 on the first accepted beat.
  - Beat 32 accepted with tlast=1: lutValid=1 next cycle, go to IDLE.
  - Beat 32 accepted with tlast=0: lutValid=1, go to DRAIN.
  - tlast on a beat before 32: abort; lutValid stays 0, go to IDLE.
- DRAIN: s_fog_lut_axis_tready=1, beats are discarded, go to IDLE on the tlast beat.
- Evaluation pipeline: 3 stages, latency exactly 3 cycles when unstalled, throughput 1 per cycle.
  - Advance enable ce = !m_fog_axis_tvalid || m_fog_axis_tready.
  - s_depth_axis_tready = ce && lutValid && FSM==IDLE && !s_fog_lut_axis_tvalid.
- Stage 1: d = z - Z0 (17-bit signed).
  - d<0: idx=0, frac=0.
  - Otherwise q = (d<<8)>>S (25 bits), idx = q[12:8], frac = q[7:0].
  - If q[24:13] != 0 (overflow): idx=31, frac=255.
- Stage 2: synchronous table read of entry idx; frac and tuser are registered alongside.
- Stage 3: r = offset + ((slope * frac) >>> 8), computed in 18-bit signed. Output is the integer part r[15:8], clamped to 0 when r<0 and to 255 when r>=256.
- Reset mid-load: lutValid=0 and the table is treated as invalid. Reset mid-evaluation: all in-flight samples are discarded.

Decomposition:
- Shared package: FOG_LUT_WORDS=33, FOG_LUT_ENTRIES=32, the word-0 field positions (Z0, S), and the entry field positions (offset, slope).
- One sub-module, fog_lut_ram: 32x32 simple dual-port RAM with one write port and one registered read port.

Test Plan:
- Load Z0=1000, S=8; entry 2 = offset 0x4000, slope 0x0100; send z=1000+2*256+128 -> intensity 64+0.5 -> tdata=0x40, exactly 3 cycles after acceptance.
- z=500, below Z0 -> entry 0 used with frac=0 -> tdata = entry0 offset[15:8].
- z=0xFFFF with S=0 -> overflow clamp idx=31, frac=255. With offset 0xFF00 and slope 0x7FFF -> tdata=255. With offset 0 and slope 0x8000 -> tdata=0.
- LUT stream with tlast on beat 10 -> lutValid=0, s_depth_axis_tready=0. A subsequent full load -> lutValid=1.
- 34-beat stream with tlast on beat 33 -> table taken from beats 0..32, extra beat discarded, FSM back to IDLE.
- Back-to-back 8 depths with m_fog_axis_tready toggling 1,0,0,1 -> no loss, duplication or reordering; tuser stays matched to each result.

Source files
------------

// File: rtl/fog_lut_evaluator_pkg.sv
// fog_lut_evaluator_pkg: table geometry, word field positions and load FSM states
package fog_lut_evaluator_pkg;
  localparam int FOG_LUT_WORDS = 33;
  localparam int FOG_LUT_ENTRIES = 32;
  localparam int Z0_LSB = 0;
  localparam int Z0_W = 16;
  localparam int S_LSB = 16;
  localparam int S_W = 5;
  localparam int OFF_LSB = 16;
  localparam int OFF_W = 16;
  localparam int SLOPE_LSB = 0;
  localparam int SLOPE_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} load_state_t;
  // acc is offset + slope*frac scaled by 256; acc[25:8] is the Q8.8 result
  function automatic logic [7:0] clamp_intensity(input logic [25:0] acc);
    return acc[25] ? 8'd0 : (acc[24] ? 8'hFF : acc[23:16]);
  endfunction
endpackage

// File: rtl/fog_lut_ram.sv
// fog_lut_ram: entry table, one write port and one registered, enabled read port
module fog_lut_ram
  import fog_lut_evaluator_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic        i_re,
  input  logic [4:0]  i_raddr,
  output logic [31:0] o_rdata
);
  logic [31:0] r_mem [0:FOG_LUT_ENTRIES-1];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fog_lut_evaluator.sv
// fog_lut_evaluator: loads the 33-word fog table and maps depth to 8-bit fog intensity
module fog_lut_evaluator
  import fog_lut_evaluator_pkg::*;
#(
  parameter int CMD_STREAM_WIDTH = 32,
  parameter int USER_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic                        s_fog_lut_axis_tvalid,
  output logic                        s_fog_lut_axis_tready,
  input  logic                        s_fog_lut_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s_fog_lut_axis_tdata,
  input  logic                        s_depth_axis_tvalid,
  output logic                        s_depth_axis_tready,
  input  logic [15:0]                 s_depth_axis_tdata,
  input  logic [USER_WIDTH-1:0]       s_depth_axis_tuser,
  output logic                        m_fog_axis_tvalid,
  input  logic                        m_fog_axis_tready,
  output logic [7:0]                  m_fog_axis_tdata,
  output logic [USER_WIDTH-1:0]       m_fog_axis_tuser,
  output logic                        lutValid
);
  load_state_t r_state;
  logic [5:0] r_cnt;
  logic r_lut_valid;
  logic [Z0_W-1:0] r_z0;
  logic [S_W-1:0] r_shift;
  logic r_v1, r_v2, r_vo;
  logic [4:0] r_idx1;
  logic [7:0] r_frac1, r_frac2, r_datao;
  logic [USER_WIDTH-1:0] r_user1, r_user2, r_usero;
  logic w_ce, w_empty, w_we, w_last_word, w_accept;
  logic [16:0] w_d;
  logic [24:0] w_q;
  logic w_ovf;
  logic [4:0] w_idx;
  logic [7:0] w_frac;
  logic [31:0] w_entry;
  logic [25:0] w_acc;

  assign w_ce = !r_vo || m_fog_axis_tready;
  assign w_empty = !(r_v1 || r_v2 || r_vo);
  assign w_last_word = r_cnt == 6'(FOG_LUT_WORDS - 1);
  assign w_we = r_state == ST_LOAD && s_fog_lut_axis_tvalid && r_cnt != 6'd0;
  assign s_fog_lut_axis_tready = r_state != ST_IDLE;
  assign s_depth_axis_tready = w_ce && r_lut_valid && r_state == ST_IDLE && !s_fog_lut_axis_tvalid;
  assign w_accept = s_depth_axis_tvalid && s_depth_axis_tready;
  assign m_fog_axis_tvalid = r_vo;
  assign m_fog_axis_tdata = r_datao;
  assign m_fog_axis_tuser = r_usero;
  assign lutValid = r_lut_valid;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_lut_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (s_fog_lut_axis_tvalid && w_empty) begin
          r_state <= ST_LOAD;
          r_cnt <= '0;
        end
        ST_LOAD: if (s_fog_lut_axis_tvalid) begin
          r_cnt <= r_cnt + 6'd1;
          r_lut_valid <= w_last_word;
          if (w_last_word) r_state <= s_fog_lut_axis_tlast ? ST_IDLE : ST_DRAIN;
          else if (s_fog_lut_axis_tlast) r_state <= ST_IDLE;
        end
        ST_DRAIN: if (s_fog_lut_axis_tvalid && s_fog_lut_axis_tlast) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (r_state == ST_LOAD && s_fog_lut_axis_tvalid && r_cnt == 6'd0) begin
      r_z0 <= s_fog_lut_axis_tdata[Z0_LSB +: Z0_W];
      r_shift <= s_fog_lut_axis_tdata[S_LSB +: S_W];
    end
  end

  // word n of the stream lands in entry n-1; word 32 wraps to address 31 via 5-bit subtract
  fog_lut_ram u_ram (
    .clk     (aclk),
    .i_we    (w_we),
    .i_waddr (r_cnt[4:0] - 5'd1),
    .i_wdata (s_fog_lut_axis_tdata),
    .i_re    (w_ce),
    .i_raddr (r_idx1),
    .o_rdata (w_entry)
  );

  always_comb begin
    w_d = {1'b0, s_depth_axis_tdata} - {1'b0, r_z0};
    w_q = {1'b0, w_d[15:0], 8'h00} >> r_shift;
    w_ovf = |w_q[24:13];
    w_idx = w_d[16] ? 5'd0 : (w_ovf ? 5'd31 : w_q[12:8]);
    w_frac = w_d[16] ? 8'd0 : (w_ovf ? 8'hFF : w_q[7:0]);
    w_acc = {2'b00, w_entry[OFF_LSB +: OFF_W], 8'h00}
          + {{10{w_entry[SLOPE_LSB + SLOPE_W - 1]}}, w_entry[SLOPE_LSB +: SLOPE_W]} * {18'h0, r_frac2};
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_vo <= 1'b0;
    end else if (w_ce) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_vo <= r_v2;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_ce) begin
      r_idx1 <= w_idx;
      r_frac1 <= w_frac;
      r_user1 <= s_depth_axis_tuser;
      r_frac2 <= r_frac1;
      r_user2 <= r_user1;
      r_datao <= clamp_intensity(w_acc);
      r_usero <= r_user2;
    end
  end
endmodule
